nebula_wb_gpio_walker: RTL and testbench
========================================

# nebula_wb_gpio_walker

Wishbone classic responder in the user project area. It holds a small control/status register bank that the management core reads and writes over the Caravel Wishbone port. It also runs a walking-one sequencer that drives 34 user GPIOs (mprj_io[37:5], mprj_io[0]). Firmware on the management core starts the walk with register writes, and the chip-level bench observes the result on the GPIO pins.

## Interface
Parameters:
- BASE_ADDR, 32'h3000_0000, block base address; decode compares adr[31:8] against BASE_ADDR[31:8].
- NBITS, 34, GPIO width driven by the walker.
- DIV_W, 24, width of the step-period register.

Ports:
- wb_clk_i  in  1  single clock for the block.
- wb_rst_i  in  1  reset; synchronous and active-high.
- wbs_cyc_i  in  1  bus cycle valid.
- wbs_stb_i  in  1  strobe.
- wbs_we_i  in  1  1 = write.
- wbs_sel_i  in  4  byte lane selects.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  single-cycle acknowledge.
- wbs_dat_o  out  32  read data, valid while wbs_ack_o is high.
- gpio_out  out  NBITS  walker pattern.
- gpio_oeb  out  NBITS  output enable, active-low.
- irq_o  out  1  one-cycle pulse when a finite run completes.

## Operation
Register map (offset from BASE_ADDR):
- 0x00 CTRL, R/W. bit0 EN starts or runs the walk; bit2 OE; bits[15:8] ITER, where 0 means run forever. Other bits read 0.
- 0x04 DIV, R/W. bits[DIV_W-1:0] give the number of clocks each step is held. A value of 0 behaves as 1.
- 0x08 STATUS. bit0 BUSY (RO); bit1 DONE (write 1 to clear); bits[15:8] iterations completed (RO, wraps at 256).
- 0x0C PAT_LO, RO. Returns gpio_out[31:0].
- 0x10 PAT_HI, RO. Returns gpio_out[33:32] in bits[1:0].
- Any other in-block offset reads 0 and ignores writes, but is still acknowledged.
- Addresses outside the block are never acknowledged.

Write rules:
- wbs_sel_i masks writes per byte lane on CTRL and DIV.
- gpio_oeb = OE ? all zeros : all ones. OE takes effect on the cycle after the write.

Walker FSM:
- IDLE: gpio_out = 0. Moves to WALK when EN=1 and DONE=0.
- WALK: gpio_out = 1 << idx. Each idx is held DIV cycles, for idx = 0 to NBITS-1. After idx NBITS-1 completes, moves to GAP.
- GAP: gpio_out = 0 for DIV cycles, then increments the iteration count.
  - If ITER=0, or the count is below ITER, returns to WALK with idx=0.
  - Otherwise goes to IDLE, sets DONE=1, pulses irq_o and clears EN.

Rules for changes during a run:
- EN written 0 while BUSY: abort to IDLE on the next edge, gpio_out becomes 0, DONE is not set.
- EN written 1 while already BUSY: no restart.
- DIV written mid-run: the new value is loaded at the next step boundary. The current step finishes with the old count.
- DONE=1 blocks restart until firmware clears it. Clearing DONE and setting EN in the same transaction is allowed only via two writes. EN written while DONE=1 is stored but idles until DONE clears.
- BUSY = (state != IDLE).

## Timing
- Reset values: wbs_ack_o=0, wbs_dat_o=0, gpio_out=0, gpio_oeb=all ones, irq_o=0. All registers are 0 except DIV, which resets to 1. State is IDLE.
- Wishbone handshake:
  - wbs_ack_o rises on the edge after a decoded cyc&stb with ack low, and stays high exactly one cycle. There is never a second ack for the same strobe.
  - A held strobe gets a new ack every second cycle.
  - Register writes commit on the edge where ack rises.
- Start latency: after a CTRL write with EN=1, gpio_out = 34'h1 on the edge following the ack cycle.
- Step counter loads DIV-1 and counts down to 0, then advances. Each pattern is therefore visible for exactly DIV cycles.
- Full run length is (NBITS+1)·DIV cycles per iteration.
- irq_o is high on the same edge DONE sets.
- Reset asserted mid-run returns every output to its reset value on the next edge, regardless of bus activity.

## Structure
- Package nebula_wb_pkg holds:
  - register offset localparams;
  - CTRL/STATUS bit-position constants;
  - the walker state enum (IDLE, WALK, GAP);
  - the NBITS default.
- Sub-module gpio_walker_core contains the FSM, step counter, idx and iteration counter. Its inputs are en, div, iter and done_clr. Its outputs are pattern, busy, done_set and iter_cnt.
- The top level holds Wishbone decode, the ack flop and the register bank.

## Test plan
- Reset with no bus activity for 10 cycles -> ack=0, gpio_out=0, gpio_oeb=34'h3_FFFF_FFFF; read DIV returns 1.
- Write DIV=4, then CTRL=0x0105 (EN, OE, ITER=1) -> gpio_oeb=0. gpio_out steps 0x1, 0x2 … 0x2_0000_0000, each held 4 cycles, then 0 for 4 cycles. DONE=1 and irq_o pulses once. STATUS reads 0x0102.
- Read offset 0x20 and BASE+0x100 -> 0x20 acked with data 0; the out-of-block address is never acked. Held strobe -> ack toggles every other cycle.
- Byte write CTRL with sel=4'b0010, dat=0x0000_0300 -> ITER=3, EN unchanged; run completes 3 iterations.
- Mid-walk at idx=10, write CTRL EN=0 -> gpio_out=0 next edge, BUSY=0, DONE=0, no irq.
- Mid-walk, write DIV from 2 to 6 -> the current step finishes at 2 cycles, the next step holds 6 cycles. Reset asserted during the run -> all outputs return to reset values the following edge.

Source files
------------

// File: rtl/nebula_wb_pkg.sv
// Shared constants, state encoding and helpers for the Wishbone GPIO walker.
// Register offsets are byte offsets from the block base address.
package nebula_wb_pkg;

    localparam int NBITS_DEFAULT = 34;

    localparam logic [7:0] OFF_CTRL   = 8'h00;
    localparam logic [7:0] OFF_DIV    = 8'h04;
    localparam logic [7:0] OFF_STATUS = 8'h08;
    localparam logic [7:0] OFF_PAT_LO = 8'h0C;
    localparam logic [7:0] OFF_PAT_HI = 8'h10;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_OE       = 2;
    localparam int CTRL_ITER_LSB = 8;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_CNT_LSB = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WALK = 2'd1,
        GAP  = 2'd2
    } walker_state_t;

    // Replace only the byte lanes whose select bit is set.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  sel);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) r[8*b +: 8] = new_w[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/gpio_walker_core.sv
// Walking-one sequencer: steps a single set bit across NBITS outputs, holding
// each position DIV clocks, followed by an all-zero gap of DIV clocks.
module gpio_walker_core
    import nebula_wb_pkg::*;
#(
    parameter int NBITS = NBITS_DEFAULT,
    parameter int DIV_W = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [DIV_W-1:0]     div,
    input  logic [7:0]           iter,
    input  logic                 done_clr,
    output logic [NBITS-1:0]     pattern,
    output logic                 busy,
    output logic                 done_set,
    output logic [7:0]           iter_cnt,
    output walker_state_t        state_dbg
);

    localparam int IDX_W = $clog2(NBITS);

    walker_state_t    state, state_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic [DIV_W-1:0] cnt, cnt_nxt, load_val;
    logic [7:0]       iter_cnt_nxt, cnt_inc;
    logic             done_q, done_nxt;

    // A DIV of zero is treated as one, so both load a count of zero.
    assign load_val = (div == '0) ? '0 : div - 1'b1;
    assign cnt_inc  = iter_cnt + 8'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            cnt      <= '0;
            iter_cnt <= '0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            cnt      <= cnt_nxt;
            iter_cnt <= iter_cnt_nxt;
            done_q   <= done_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        cnt_nxt      = cnt;
        iter_cnt_nxt = iter_cnt;
        done_set     = 1'b0;
        done_nxt     = done_q & ~done_clr;
        case (state)
            IDLE: begin
                if (en && !done_q) begin
                    state_nxt    = WALK;
                    idx_nxt      = '0;
                    cnt_nxt      = load_val;
                    iter_cnt_nxt = '0;
                end
            end
            WALK: begin
                if (!en) begin
                    state_nxt = IDLE;
                end else if (cnt != '0) begin
                    cnt_nxt = cnt - 1'b1;
                end else begin
                    // Step boundary: the reload picks up any freshly written DIV.
                    cnt_nxt = load_val;
                    if (idx == IDX_W'(NBITS - 1)) state_nxt = GAP;
                    else                          idx_nxt   = idx + 1'b1;
                end
            end
            GAP: begin
                if (!en) begin
                    state_nxt = IDLE;
                end else if (cnt != '0) begin
                    cnt_nxt = cnt - 1'b1;
                end else begin
                    iter_cnt_nxt = cnt_inc;
                    if (iter == 8'd0 || cnt_inc < iter) begin
                        state_nxt = WALK;
                        idx_nxt   = '0;
                        cnt_nxt   = load_val;
                    end else begin
                        state_nxt = IDLE;
                        done_set  = 1'b1;
                        done_nxt  = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign pattern   = (state == WALK) ? ({{(NBITS-1){1'b0}}, 1'b1} << idx) : '0;
    assign busy      = (state != IDLE);
    assign state_dbg = state;

endmodule

// File: rtl/nebula_wb_gpio_walker.sv
// Wishbone classic responder with a control/status bank driving the GPIO walker.
// Acks are single-cycle and registered; writes commit on the edge the ack rises.
module nebula_wb_gpio_walker
    import nebula_wb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          NBITS     = NBITS_DEFAULT,
    parameter int          DIV_W     = 24
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    output logic [NBITS-1:0]  gpio_out,
    output logic [NBITS-1:0]  gpio_oeb,
    output logic              irq_o
);

    logic             hit, req, wr, done_clr;
    logic [7:0]       word_off;
    logic             ctrl_en, ctrl_oe, status_done;
    logic [7:0]       ctrl_iter;
    logic [DIV_W-1:0] div_q;
    logic [31:0]      ctrl_word, status_word, rdata, ctrl_merged, div_merged;
    logic [63:0]      pat_ext;
    logic [NBITS-1:0] pattern;
    logic             busy, done_set;
    logic [7:0]       iter_cnt;
    walker_state_t    walker_state;
    logic             unused_ok;

    assign hit      = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign word_off = {wbs_adr_i[7:2], 2'b00};
    // Blocking on ack keeps a held strobe from being acked twice in a row.
    assign req      = wbs_cyc_i & wbs_stb_i & hit & ~wbs_ack_o;
    assign wr       = req & wbs_we_i;
    assign done_clr = wr && (word_off == OFF_STATUS) && wbs_sel_i[0] && wbs_dat_i[STAT_DONE];

    always_comb begin
        ctrl_word                        = '0;
        ctrl_word[CTRL_EN]               = ctrl_en;
        ctrl_word[CTRL_OE]               = ctrl_oe;
        ctrl_word[CTRL_ITER_LSB +: 8]    = ctrl_iter;
        status_word                      = '0;
        status_word[STAT_BUSY]           = busy;
        status_word[STAT_DONE]           = status_done;
        status_word[STAT_CNT_LSB +: 8]   = iter_cnt;
    end

    assign ctrl_merged = byte_merge(ctrl_word, wbs_dat_i, wbs_sel_i);
    assign div_merged  = byte_merge(32'(div_q), wbs_dat_i, wbs_sel_i);
    assign pat_ext     = 64'(pattern);

    always_comb begin
        rdata = '0;
        case (word_off)
            OFF_CTRL:   rdata = ctrl_word;
            OFF_DIV:    rdata = 32'(div_q);
            OFF_STATUS: rdata = status_word;
            OFF_PAT_LO: rdata = pat_ext[31:0];
            OFF_PAT_HI: rdata = pat_ext[63:32];
            default:    rdata = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wbs_ack_o   <= 1'b0;
            wbs_dat_o   <= '0;
            irq_o       <= 1'b0;
            ctrl_en     <= 1'b0;
            ctrl_oe     <= 1'b0;
            ctrl_iter   <= '0;
            div_q       <= DIV_W'(1);
            status_done <= 1'b0;
        end else begin
            wbs_ack_o <= req;
            wbs_dat_o <= (req && !wbs_we_i) ? rdata : '0;
            irq_o     <= done_set;
            if (wr && word_off == OFF_CTRL) begin
                ctrl_en   <= ctrl_merged[CTRL_EN];
                ctrl_oe   <= ctrl_merged[CTRL_OE];
                ctrl_iter <= ctrl_merged[CTRL_ITER_LSB +: 8];
            end
            if (wr && word_off == OFF_DIV) div_q <= div_merged[DIV_W-1:0];
            if (done_clr) status_done <= 1'b0;
            // Completion wins over a same-cycle CTRL write so EN ends up cleared.
            if (done_set) begin
                status_done <= 1'b1;
                ctrl_en     <= 1'b0;
            end
        end
    end

    gpio_walker_core #(
        .NBITS (NBITS),
        .DIV_W (DIV_W)
    ) u_core (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .en        (ctrl_en),
        .div       (div_q),
        .iter      (ctrl_iter),
        .done_clr  (done_clr),
        .pattern   (pattern),
        .busy      (busy),
        .done_set  (done_set),
        .iter_cnt  (iter_cnt),
        .state_dbg (walker_state)
    );

    assign gpio_out  = pattern;
    assign gpio_oeb  = ctrl_oe ? '0 : '1;
    assign unused_ok = ^{wbs_adr_i[1:0], ctrl_merged, div_merged, walker_state};

endmodule

// File: tb/tb_nebula_wb_gpio_walker.sv
// Directed bench for the Wishbone GPIO walker: register access, walk timing,
// byte-lane writes, abort, mid-run DIV change and reset during a run.
`timescale 1ns/1ps
module tb_nebula_wb_gpio_walker;

    localparam int          NBITS = 34;
    localparam logic [31:0] BASE  = 32'h3000_0000;
    localparam logic [33:0] ONES  = 34'h3_FFFF_FFFF;
    localparam logic [33:0] ONE   = 34'h1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = '0, dat_w = '0;
    logic        ack;
    logic [31:0] dat_r;
    logic [33:0] gpio_out, gpio_oeb;
    logic        irq;

    int checks = 0;
    int passes = 0;
    int irq_seen = 0;

    always #5 clk = ~clk;
    always @(negedge clk) if (irq) irq_seen++;

    nebula_wb_gpio_walker #(
        .BASE_ADDR (BASE),
        .NBITS     (NBITS),
        .DIV_W     (24)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wbs_cyc_i (cyc),
        .wbs_stb_i (stb),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_adr_i (adr),
        .wbs_dat_i (dat_w),
        .wbs_ack_o (ack),
        .wbs_dat_o (dat_r),
        .gpio_out  (gpio_out),
        .gpio_oeb  (gpio_oeb),
        .irq_o     (irq)
    );

    initial begin
        #300000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    // Drives one transaction and returns at #1 after the edge where ack rose.
    task automatic wb_xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] rd, output logic got);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d; sel = s;
        got = 1'b0; rd = '0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (ack) begin
                got = 1'b1;
                rd  = dat_r;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] rd;
        logic        got;
        wb_xfer(a, 1'b1, d, s, rd, got);
        checks++;
        if (got !== 1'b1) $display("FAIL wb_write_ack addr=%h ack=%b required 1 (rd=%h)", a, got, rd);
        else passes++;
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] rd);
        logic got;
        wb_xfer(a, 1'b0, 32'h0, 4'hF, rd, got);
        checks++;
        if (got !== 1'b1) $display("FAIL wb_read_ack addr=%h ack=%b required 1", a, got);
        else passes++;
    endtask

    // Samples a finite run right after the starting CTRL write and counts
    // deviations from the expected walk/gap/irq timeline.
    task automatic watch_run(input int div, input int iters, output int errs,
                             output int bad_c, output logic [34:0] bad_act,
                             output logic [34:0] bad_exp);
        int          p, total, r, c;
        logic [33:0] e;
        logic        ei;
        p = (NBITS + 1) * div;
        total = iters * p;
        errs = 0; bad_c = 0; bad_act = '0; bad_exp = '0;
        for (int n = 0; n < total + 5; n++) begin
            @(negedge clk);
            c = n - 1;
            e = '0;
            ei = (c == total);
            if (c >= 0 && c < total) begin
                r = c % p;
                if (r < NBITS * div) e = ONE << (r / div);
            end
            if (gpio_out !== e || irq !== ei) begin
                if (errs == 0) begin
                    bad_c = c; bad_act = {irq, gpio_out}; bad_exp = {ei, e};
                end
                errs++;
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (ack !== 1'b0 || irq !== 1'b0) $display("FAIL reset_ack_irq ack=%b irq=%b required 0 0", ack, irq);
        else passes++;
        checks++;
        if (gpio_out !== 34'h0) $display("FAIL reset_gpio_out got %h required 0", gpio_out);
        else passes++;
        checks++;
        if (gpio_oeb !== ONES) $display("FAIL reset_gpio_oeb got %h required %h", gpio_oeb, ONES);
        else passes++;
        wb_read(BASE + 32'h04, rd);
        checks++;
        if (rd !== 32'h1) $display("FAIL reset_div got %h required 1", rd);
        else passes++;
        wb_read(BASE + 32'h00, rd);
        checks++;
        if (rd !== 32'h0) $display("FAIL reset_ctrl got %h required 0", rd);
        else passes++;
    endtask

    task automatic test_decode();
        logic [31:0] rd;
        int          acks;
        logic        exp_ack;
        wb_read(BASE + 32'h20, rd);
        checks++;
        if (rd !== 32'h0) $display("FAIL decode_hole got %h required 0", rd);
        else passes++;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h100; sel = 4'hF;
        acks = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (ack) acks++;
        end
        cyc = 1'b0; stb = 1'b0;
        checks++;
        if (acks !== 0) $display("FAIL decode_outside acks=%0d required 0", acks);
        else passes++;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; adr = BASE + 32'h04;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            exp_ack = (i % 2 == 0);
            checks++;
            if (ack !== exp_ack) $display("FAIL held_strobe_ack cycle=%0d got %b required %b", i, ack, exp_ack);
            else passes++;
        end
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_run();
        logic [31:0] rd;
        int          errs, bad_c, irq0;
        logic [34:0] ba, be;
        wb_write(BASE + 32'h04, 32'd4, 4'hF);
        irq0 = irq_seen;
        wb_write(BASE + 32'h00, 32'h0105, 4'hF);
        checks++;
        if (gpio_oeb !== 34'h0) $display("FAIL run1_oeb got %h required 0", gpio_oeb);
        else passes++;
        watch_run(4, 1, errs, bad_c, ba, be);
        checks++;
        if (errs !== 0) $display("FAIL run1_walk errors=%0d first at cycle %0d got %h required %h", errs, bad_c, ba, be);
        else passes++;
        checks++;
        if (irq_seen - irq0 !== 1) $display("FAIL run1_irq_count got %0d required 1", irq_seen - irq0);
        else passes++;
        wb_read(BASE + 32'h08, rd);
        checks++;
        if (rd !== 32'h0102) $display("FAIL run1_status got %h required 0102", rd);
        else passes++;
    endtask

    task automatic test_done_block();
        logic [31:0] rd;
        wb_write(BASE + 32'h00, 32'h0105, 4'hF);
        repeat (5) @(negedge clk);
        checks++;
        if (gpio_out !== 34'h0) $display("FAIL done_block_gpio got %h required 0", gpio_out);
        else passes++;
        wb_read(BASE + 32'h08, rd);
        checks++;
        if (rd !== 32'h0102) $display("FAIL done_block_status got %h required 0102", rd);
        else passes++;
        wb_read(BASE + 32'h00, rd);
        checks++;
        if (rd !== 32'h0105) $display("FAIL done_block_ctrl got %h required 0105", rd);
        else passes++;
    endtask

    task automatic test_byte_write();
        logic [31:0] rd;
        int          errs, bad_c;
        logic [34:0] ba, be;
        wb_write(BASE + 32'h00, 32'h0104, 4'hF);
        wb_write(BASE + 32'h08, 32'h0000_0002, 4'hF);
        wb_write(BASE + 32'h00, 32'h0000_0300, 4'b0010);
        wb_read(BASE + 32'h00, rd);
        checks++;
        if (rd !== 32'h0304) $display("FAIL byte_ctrl got %h required 0304", rd);
        else passes++;
        wb_write(BASE + 32'h00, 32'h0000_0005, 4'b0001);
        watch_run(4, 3, errs, bad_c, ba, be);
        checks++;
        if (errs !== 0) $display("FAIL run3_walk errors=%0d first at cycle %0d got %h required %h", errs, bad_c, ba, be);
        else passes++;
        wb_read(BASE + 32'h08, rd);
        checks++;
        if (rd !== 32'h0302) $display("FAIL run3_status got %h required 0302", rd);
        else passes++;
    endtask

    task automatic test_abort();
        logic [31:0] rd;
        int          irq0;
        logic        found;
        wb_write(BASE + 32'h08, 32'h2, 4'hF);
        wb_write(BASE + 32'h04, 32'd2, 4'hF);
        wb_write(BASE + 32'h00, 32'h0005, 4'hF);
        irq0 = irq_seen;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (gpio_out === (ONE << 10)) found = 1'b1;
        end
        checks++;
        if (found !== 1'b1) $display("FAIL abort_reach_idx10 found=%b required 1", found);
        else passes++;
        wb_write(BASE + 32'h00, 32'h0004, 4'hF);
        @(posedge clk); #1;
        checks++;
        if (gpio_out !== 34'h0) $display("FAIL abort_gpio got %h required 0", gpio_out);
        else passes++;
        repeat (4) @(negedge clk);
        wb_read(BASE + 32'h08, rd);
        checks++;
        if (rd !== 32'h0) $display("FAIL abort_status got %h required 0", rd);
        else passes++;
        checks++;
        if (irq_seen - irq0 !== 0) $display("FAIL abort_irq got %0d required 0", irq_seen - irq0);
        else passes++;
    endtask

    task automatic test_div_change_and_reset();
        logic [31:0] rd;
        logic [33:0] e;
        logic        found;
        wb_write(BASE + 32'h00, 32'h0005, 4'hF);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (gpio_out === (ONE << 3)) found = 1'b1;
        end
        checks++;
        if (found !== 1'b1) $display("FAIL divchg_reach_idx3 found=%b required 1", found);
        else passes++;
        wb_write(BASE + 32'h04, 32'd6, 4'hF);
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            e = (n == 0) ? (ONE << 3) : (n <= 6) ? (ONE << 4) : (ONE << 5);
            checks++;
            if (gpio_out !== e) $display("FAIL divchg_step sample=%0d got %h required %h", n, gpio_out, e);
            else passes++;
        end
        wb_read(BASE + 32'h0C, rd);
        checks++;
        if (rd !== 32'h20) $display("FAIL pat_lo got %h required 00000020", rd);
        else passes++;
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (gpio_out === (ONE << 33)) found = 1'b1;
        end
        checks++;
        if (found !== 1'b1) $display("FAIL divchg_reach_idx33 found=%b required 1", found);
        else passes++;
        wb_read(BASE + 32'h10, rd);
        checks++;
        if (rd !== 32'h2) $display("FAIL pat_hi got %h required 2", rd);
        else passes++;
        // Hold a read strobe so ack would rise again on the reset edge.
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h00; sel = 4'hF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (ack !== 1'b0 || irq !== 1'b0 || dat_r !== 32'h0)
            $display("FAIL midrun_reset_bus ack=%b irq=%b dat=%h required 0 0 0", ack, irq, dat_r);
        else passes++;
        checks++;
        if (gpio_out !== 34'h0 || gpio_oeb !== ONES)
            $display("FAIL midrun_reset_gpio out=%h oeb=%h required 0 %h", gpio_out, gpio_oeb, ONES);
        else passes++;
        cyc = 1'b0; stb = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        wb_read(BASE + 32'h04, rd);
        checks++;
        if (rd !== 32'h1) $display("FAIL post_reset_div got %h required 1", rd);
        else passes++;
        wb_read(BASE + 32'h08, rd);
        checks++;
        if (rd !== 32'h0) $display("FAIL post_reset_status got %h required 0", rd);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_decode();
        test_single_run();
        test_done_block();
        test_byte_write();
        test_abort();
        test_div_change_and_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
